// File: rtl/inference_sequencer_pkg.sv
// Shared definitions for the inference sequencer and CORE_TOP.
//   - Default network geometry (input grid size, output-layer size, value width)
//   - Sequencer FSM state encoding
//   - Widths of the class index and completed-run counter
package cortez_seq_pkg;

  localparam int DEF_INPUT_SIZE = 16;
  localparam int DEF_OL_NEURONS = 5;
  localparam int DEF_FP_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_TMO_WIDTH  = 16;

  // RESULT_CLASS is 3 bits wide, so OL_NEURONS must lie in 2..8.
  localparam int CLASS_W = 3;
  localparam int DONE_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SCAN   = 3'd3,
    ST_HOLD   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/inference_sequencer_if.sv
// Bus bundle between the inference sequencer and its neighbours.
//   Grid push channel : GRID_IN, GRID_VALID -> / <- GRID_READY
//   Network channel   : NET_VALUES_IN, NET_VALID_IN -> / <- NET_VALUES_OUT, NET_VALID_OUT
//   Result channel    : RESULT_VALUES, RESULT_CLASS, RESULT_TIMEOUT, RESULT_VALID -> / <- RESULT_READY
// modport slave  : the sequencer's view
// modport master : the surrounding logic's view (regfile, NETWORK, result consumer)
interface inference_sequencer_if
  import cortez_seq_pkg::*;
#(
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int OL_NEURONS = DEF_OL_NEURONS,
  parameter int FP_WIDTH   = DEF_FP_WIDTH
);

  logic [INPUT_SIZE*FP_WIDTH-1:0] GRID_IN;
  logic                           GRID_VALID;
  logic                           GRID_READY;

  logic [INPUT_SIZE*FP_WIDTH-1:0] NET_VALUES_IN;
  logic                           NET_VALID_IN;
  logic [OL_NEURONS*FP_WIDTH-1:0] NET_VALUES_OUT;
  logic                           NET_VALID_OUT;

  logic [OL_NEURONS*FP_WIDTH-1:0] RESULT_VALUES;
  logic [CLASS_W-1:0]             RESULT_CLASS;
  logic                           RESULT_TIMEOUT;
  logic                           RESULT_VALID;
  logic                           RESULT_READY;

  modport slave (
    input  GRID_IN, GRID_VALID, NET_VALUES_OUT, NET_VALID_OUT, RESULT_READY,
    output GRID_READY, NET_VALUES_IN, NET_VALID_IN,
           RESULT_VALUES, RESULT_CLASS, RESULT_TIMEOUT, RESULT_VALID
  );

  modport master (
    output GRID_IN, GRID_VALID, NET_VALUES_OUT, NET_VALID_OUT, RESULT_READY,
    input  GRID_READY, NET_VALUES_IN, NET_VALID_IN,
           RESULT_VALUES, RESULT_CLASS, RESULT_TIMEOUT, RESULT_VALID
  );

endinterface

// File: rtl/inference_sequencer_fifo.sv
// seq_grid_fifo: synchronous FIFO holding whole input grids.
//   CLK, rstn  : clock, synchronous active-low reset (empties the FIFO)
//   push_valid : write request; accepted when push_ready is high
//   push_ready : not full (registered)
//   wr_data    : grid to store, kept verbatim
//   pop        : read request; ignored when empty
//   rd_data    : head entry (valid while empty is low)
//   empty      : no entries (registered)
// DEPTH must be a power of two so the pointers wrap naturally.
module seq_grid_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             rstn,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_valid && !full_q;
  assign do_pop  = pop && !empty_q;

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data    = mem[rd_ptr];
  assign push_ready = !full_q;
  assign empty      = empty_q;

endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: queues input grids, launches one NETWORK evaluation at a
// time, waits (with optional timeout) for the result, finds the winning class
// with a sequential signed argmax and offers the result over valid/ready.
//   CLK, rstn      : clock, synchronous active-low reset
//   ENABLE         : permits new launches (a run in progress always completes)
//   TIMEOUT_CYCLES : max cycles spent waiting for NET_VALID_OUT, 0 = wait forever
//   bus (slave)    : grid push, network and result channels
//   BUSY           : FSM not idle
//   DONE_COUNT     : completed runs including timeouts, wraps at 16 bits
module inference_sequencer
  import cortez_seq_pkg::*;
#(
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int OL_NEURONS = DEF_OL_NEURONS,
  parameter int FP_WIDTH   = DEF_FP_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TMO_WIDTH  = DEF_TMO_WIDTH
) (
  input  logic                 CLK,
  input  logic                 rstn,
  input  logic                 ENABLE,
  input  logic [TMO_WIDTH-1:0] TIMEOUT_CYCLES,
  inference_sequencer_if.slave bus,
  output logic                 BUSY,
  output logic [DONE_W-1:0]    DONE_COUNT
);

  localparam int GRID_W = INPUT_SIZE * FP_WIDTH;
  localparam int OL_W   = OL_NEURONS * FP_WIDTH;
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(OL_NEURONS - 1);

  // Picks output element idx out of the packed vector as a signed value.
  function automatic logic signed [FP_WIDTH-1:0] elem_sel(
    input logic [OL_W-1:0]    vec,
    input logic [CLASS_W-1:0] idx
  );
    logic signed [FP_WIDTH-1:0] e;
    e = '0;
    for (int k = 0; k < OL_NEURONS; k++) begin
      if (idx == CLASS_W'(k)) e = vec[k*FP_WIDTH +: FP_WIDTH];
    end
    return e;
  endfunction

  seq_state_t                 state;
  logic [GRID_W-1:0]          net_values_q;
  logic                       net_valid_q;
  logic [OL_W-1:0]            res_values_q;
  logic [CLASS_W-1:0]         res_class_q;
  logic                       res_timeout_q;
  logic                       res_valid_q;
  logic [DONE_W-1:0]          done_q;
  logic [TMO_WIDTH-1:0]       tmo_cnt;
  logic [CLASS_W-1:0]         scan_idx;
  logic [CLASS_W-1:0]         best_idx;
  logic signed [FP_WIDTH-1:0] best_val;
  logic signed [FP_WIDTH-1:0] cur_val;
  logic                       cur_wins;
  logic                       tmo_expired;

  logic              fifo_ready;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [GRID_W-1:0] fifo_head;

  // The head is consumed in the same cycle it is latched into NET_VALUES_IN.
  assign fifo_pop = (state == ST_IDLE) && ENABLE && !fifo_empty;

  seq_grid_fifo #(
    .WIDTH (GRID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .rstn       (rstn),
    .push_valid (bus.GRID_VALID),
    .push_ready (fifo_ready),
    .wr_data    (bus.GRID_IN),
    .pop        (fifo_pop),
    .rd_data    (fifo_head),
    .empty      (fifo_empty)
  );

  // Argmax scans the captured copy, so NET_VALUES_OUT may change after the strobe.
  assign cur_val  = elem_sel(res_values_q, scan_idx);
  assign cur_wins = (cur_val > best_val);  // strict: ties keep the lower index

  assign tmo_expired = (TIMEOUT_CYCLES != '0) && (tmo_cnt == TIMEOUT_CYCLES - 1'b1);

  always_ff @(posedge CLK) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      net_values_q  <= '0;
      net_valid_q   <= 1'b0;
      res_values_q  <= '0;
      res_class_q   <= '0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
      done_q        <= '0;
      tmo_cnt       <= '0;
      scan_idx      <= '0;
      best_idx      <= '0;
      best_val      <= '0;
    end else begin
      net_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            net_values_q <= fifo_head;
            net_valid_q  <= 1'b1;  // high for exactly the LAUNCH cycle
            state        <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the timeout cycle takes priority.
          if (bus.NET_VALID_OUT) begin
            res_values_q <= bus.NET_VALUES_OUT;
            best_idx     <= '0;
            best_val     <= bus.NET_VALUES_OUT[FP_WIDTH-1:0];
            scan_idx     <= CLASS_W'(1);
            state        <= ST_SCAN;
          end else if (tmo_expired) begin
            res_values_q  <= '0;
            res_class_q   <= '0;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state         <= ST_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          if (cur_wins) begin
            best_val <= cur_val;
            best_idx <= scan_idx;
          end
          if (scan_idx == LAST_IDX) begin
            // Fold in the final element directly rather than spending a cycle.
            res_class_q   <= cur_wins ? scan_idx : best_idx;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state         <= ST_HOLD;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.RESULT_READY) begin
            res_valid_q <= 1'b0;
            done_q      <= done_q + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.GRID_READY     = fifo_ready;
  assign bus.NET_VALUES_IN  = net_values_q;
  assign bus.NET_VALID_IN   = net_valid_q;
  assign bus.RESULT_VALUES  = res_values_q;
  assign bus.RESULT_CLASS   = res_class_q;
  assign bus.RESULT_TIMEOUT = res_timeout_q;
  assign bus.RESULT_VALID   = res_valid_q;
  assign BUSY               = (state != ST_IDLE);
  assign DONE_COUNT         = done_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed + randomized bench for inference_sequencer. A behavioural model
// (argmax over the output list, cycle arithmetic for latencies, run counter)
// supplies every expected value.
module tb_inference_sequencer;
  import cortez_seq_pkg::*;

  localparam int IS = 16;
  localparam int OL = 5;
  localparam int FW = 8;
  localparam int TW = 16;
  localparam int GW = IS * FW;
  localparam int OW = OL * FW;

  logic          CLK = 1'b0;
  logic          rstn = 1'b0;
  logic          ENABLE = 1'b0;
  logic [TW-1:0] TIMEOUT_CYCLES = '0;
  logic          BUSY;
  logic [15:0]   DONE_COUNT;

  inference_sequencer_if #(.INPUT_SIZE(IS), .OL_NEURONS(OL), .FP_WIDTH(FW)) bus ();

  inference_sequencer #(
    .INPUT_SIZE (IS),
    .OL_NEURONS (OL),
    .FP_WIDTH   (FW),
    .FIFO_DEPTH (2),
    .TMO_WIDTH  (TW)
  ) dut (
    .CLK            (CLK),
    .rstn           (rstn),
    .ENABLE         (ENABLE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .bus            (bus),
    .BUSY           (BUSY),
    .DONE_COUNT     (DONE_COUNT)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total = 0;
  int failed = 0;
  int exp_done = 0;

  // Cycle k spans posedge k .. posedge k+1; the monitor logs the cycle in
  // which each launch pulse was high together with the grid it carried.
  int cyc = 0;
  int launch_cyc[$];
  logic [GW-1:0] launch_data[$];

  always @(posedge CLK) begin
    if (bus.NET_VALID_IN === 1'b1) begin
      launch_cyc.push_back(cyc);
      launch_data.push_back(bus.NET_VALUES_IN);
    end
    cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input logic [OW-1:0] v, input int k);
    logic signed [FW-1:0] b;
    b = v[k*FW +: FW];
    return int'(b);
  endfunction

  // Winning class: largest value, first position among equals.
  function automatic int exp_class(input logic [OW-1:0] v);
    int mx;
    mx = sval(v, 0);
    for (int k = 1; k < OL; k++) if (sval(v, k) > mx) mx = sval(v, k);
    for (int k = 0; k < OL; k++) if (sval(v, k) == mx) return k;
    return -1;
  endfunction

  function automatic logic [OW-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
    logic [OW-1:0] v;
    v[0*FW +: FW] = FW'(a);
    v[1*FW +: FW] = FW'(b);
    v[2*FW +: FW] = FW'(c);
    v[3*FW +: FW] = FW'(d);
    v[4*FW +: FW] = FW'(e);
    return v;
  endfunction

  function automatic logic [GW-1:0] rand_grid();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Mix of full-range values and values clustered around +127/-128 so that
  // ties and the signed wrap point show up often.
  function automatic logic [OW-1:0] rand_outs();
    logic [OW-1:0] v;
    for (int k = 0; k < OL; k++) begin
      if ($urandom_range(0, 1) == 1) v[k*FW +: FW] = FW'($urandom_range(0, 255));
      else v[k*FW +: FW] = FW'($urandom_range(126, 129));
    end
    return v;
  endfunction

  task automatic wait_launch(input int n);
    int k;
    k = 0;
    while (launch_cyc.size() < n && k < 100) begin
      step();
      k++;
    end
    chk("launch_seen", launch_cyc.size(), n);
  endtask

  task automatic wait_valid(output int c);
    int k;
    k = 0;
    while (bus.RESULT_VALID !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("result_seen", bus.RESULT_VALID, 1);
    c = cyc;
  endtask

  task automatic push(input logic [GW-1:0] g);
    bus.GRID_IN = g;
    bus.GRID_VALID = 1'b1;
    step();
    bus.GRID_VALID = 1'b0;
  endtask

  task automatic reply(input logic [OW-1:0] v);
    bus.NET_VALUES_OUT = v;
    bus.NET_VALID_OUT = 1'b1;
    step();
    bus.NET_VALID_OUT = 1'b0;
  endtask

  // One complete run from an idle sequencer with an empty FIFO.
  task automatic do_run(input string tag, input logic [GW-1:0] g, input logic [OW-1:0] v, input int dly);
    int t, p, w, c, n;
    n = launch_cyc.size() + 1;
    t = cyc;
    push(g);
    wait_launch(n);
    p = launch_cyc[n-1];
    chk({tag, "_launch_cyc"}, p, t + 2);
    chk({tag, "_launch_data"}, launch_data[n-1], g);
    while (cyc < p + dly) step();
    w = cyc;
    reply(v);
    wait_valid(c);
    chk({tag, "_latency"}, c, w + OL);
    chk({tag, "_class"}, bus.RESULT_CLASS, exp_class(v));
    chk({tag, "_timeout"}, bus.RESULT_TIMEOUT, 0);
    chk({tag, "_values"}, bus.RESULT_VALUES, v);
    chk({tag, "_one_pulse"}, launch_cyc.size(), n);
    bus.RESULT_READY = 1'b1;
    step();
    bus.RESULT_READY = 1'b0;
    exp_done++;
    chk({tag, "_valid_drop"}, bus.RESULT_VALID, 0);
    chk({tag, "_done"}, DONE_COUNT, exp_done);
  endtask

  initial begin
    int n, p, c, h, base;
    logic [GW-1:0] g1, g2, g3;
    logic [OW-1:0] v;
    logic [OW-1:0] rv;
    logic [2:0] rc;
    logic ok;

    bus.GRID_IN = '0;
    bus.GRID_VALID = 1'b0;
    bus.NET_VALUES_OUT = '0;
    bus.NET_VALID_OUT = 1'b0;
    bus.RESULT_READY = 1'b0;

    // Reset state
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    chk("rst_grid_ready", bus.GRID_READY, 1);
    chk("rst_result_valid", bus.RESULT_VALID, 0);
    chk("rst_net_valid_in", bus.NET_VALID_IN, 0);
    chk("rst_net_values_in", bus.NET_VALUES_IN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE_COUNT, 0);

    // Single directed run with a tie at the maximum
    ENABLE = 1'b1;
    do_run("single", rand_grid(), pack5(3, -7, 20, 20, -1), 10);
    chk("single_class_const", bus.RESULT_CLASS, 2);

    // Negative values and all-minimum boundary
    do_run("neg", rand_grid(), pack5(-128, -128, -1, -128, -2), 4);
    chk("neg_class_const", bus.RESULT_CLASS, 2);
    do_run("allmin", rand_grid(), pack5(-128, -128, -128, -128, -128), 1);
    chk("allmin_class_const", bus.RESULT_CLASS, 0);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      do_run("rand", rand_grid(), rand_outs(), $urandom_range(1, 12));
    end

    // Timeout with no response, then late strobes ignored
    TIMEOUT_CYCLES = 16'd8;
    n = launch_cyc.size() + 1;
    push(rand_grid());
    wait_launch(n);
    p = launch_cyc[n-1];
    wait_valid(c);
    chk("tmo_latency", c, p + 9);
    chk("tmo_flag", bus.RESULT_TIMEOUT, 1);
    chk("tmo_values", bus.RESULT_VALUES, 0);
    chk("tmo_class", bus.RESULT_CLASS, 0);
    reply(pack5(50, 60, 70, 80, 90));
    step();
    chk("tmo_late_values", bus.RESULT_VALUES, 0);
    chk("tmo_late_flag", bus.RESULT_TIMEOUT, 1);
    chk("tmo_late_valid", bus.RESULT_VALID, 1);
    bus.RESULT_READY = 1'b1;
    step();
    bus.RESULT_READY = 1'b0;
    exp_done++;
    chk("tmo_done", DONE_COUNT, exp_done);
    reply(pack5(1, 2, 3, 4, 5));
    step();
    step();
    chk("idle_strobe_valid", bus.RESULT_VALID, 0);
    chk("idle_strobe_busy", BUSY, 0);

    // Response on the exact timeout cycle wins
    do_run("tmo_edge", rand_grid(), rand_outs(), 8);

    // FIFO fill and back-pressure on the push side
    TIMEOUT_CYCLES = '0;
    ENABLE = 1'b0;
    base = launch_cyc.size();
    g1 = rand_grid();
    g2 = rand_grid();
    g3 = rand_grid();
    chk("fifo_ready_empty", bus.GRID_READY, 1);
    push(g1);
    chk("fifo_ready_one", bus.GRID_READY, 1);
    push(g2);
    chk("fifo_ready_full", bus.GRID_READY, 0);
    push(g3);
    chk("fifo_ready_still_full", bus.GRID_READY, 0);
    chk("fifo_no_launch_disabled", launch_cyc.size(), base);
    bus.RESULT_READY = 1'b1;
    ENABLE = 1'b1;
    for (int j = 0; j < 2; j++) begin
      wait_launch(base + j + 1);
      p = launch_cyc[base + j];
      while (cyc < p + 3) step();
      reply(rand_outs());
      exp_done++;
    end
    for (int j = 0; j < 30; j++) step();
    bus.RESULT_READY = 1'b0;
    chk("fifo_launch_count", launch_cyc.size(), base + 2);
    chk("fifo_order_0", launch_data[base], g1);
    chk("fifo_order_1", launch_data[base + 1], g2);
    chk("fifo_done", DONE_COUNT, exp_done);

    // Result back-pressure with a grid queued behind the running one
    base = launch_cyc.size();
    g1 = rand_grid();
    g2 = rand_grid();
    push(g1);
    push(g2);
    wait_launch(base + 1);
    p = launch_cyc[base];
    while (cyc < p + 2) step();
    v = rand_outs();
    reply(v);
    wait_valid(c);
    rv = bus.RESULT_VALUES;
    rc = bus.RESULT_CLASS;
    chk("bp_values", rv, v);
    chk("bp_class", rc, exp_class(v));
    ok = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (bus.RESULT_VALUES !== rv || bus.RESULT_CLASS !== rc ||
          bus.RESULT_VALID !== 1'b1 || bus.RESULT_TIMEOUT !== 1'b0) ok = 1'b0;
    end
    chk("bp_stable", ok, 1);
    chk("bp_no_launch", launch_cyc.size(), base + 1);
    chk("bp_busy", BUSY, 1);
    h = cyc;
    bus.RESULT_READY = 1'b1;
    step();
    bus.RESULT_READY = 1'b0;
    exp_done++;
    wait_launch(base + 2);
    chk("bp_next_launch_cyc", launch_cyc[base + 1], h + 2);
    chk("bp_next_launch_data", launch_data[base + 1], g2);
    reply(rand_outs());
    wait_valid(c);
    bus.RESULT_READY = 1'b1;
    step();
    bus.RESULT_READY = 1'b0;
    exp_done++;
    chk("bp_done", DONE_COUNT, exp_done);

    // Reset in the middle of WAIT with another grid queued
    base = launch_cyc.size();
    push(rand_grid());
    wait_launch(base + 1);
    step();
    push(rand_grid());
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    exp_done = 0;
    chk("mid_rst_grid_ready", bus.GRID_READY, 1);
    chk("mid_rst_valid", bus.RESULT_VALID, 0);
    chk("mid_rst_values", bus.RESULT_VALUES, 0);
    chk("mid_rst_net_values", bus.NET_VALUES_IN, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE_COUNT, exp_done);
    reply(rand_outs());
    ok = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (bus.RESULT_VALID !== 1'b0) ok = 1'b0;
    end
    chk("mid_rst_no_result", ok, 1);
    chk("mid_rst_fifo_empty", launch_cyc.size(), base + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
